// File: rtl/pipeline_stage_pkg.sv
// Shared constants and phase type for two-phase (transition-signalling) handshake blocks.
package pipeline_stage_pkg;

  localparam int unsigned DEFAULT_DATA_W      = 4;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  typedef logic phase_t;

  // A two-phase event is a transition of the phase bit.
  function automatic phase_t phase_flip(input phase_t p);
    return phase_t'(~p);
  endfunction

endpackage

// File: rtl/pipeline_stage_if.sv
// Bundled-data req/ack link for one pipeline stage; the stage itself uses the slave view.
interface pipeline_stage_if
  import pipeline_stage_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
);

  phase_t              req_in;
  phase_t              ack_out;
  logic [DATA_W-1:0]   data_in;
  phase_t              req_out;
  phase_t              ack_in;
  logic [DATA_W-1:0]   data_out;

  // Environment side: upstream producer plus downstream consumer.
  modport master (
    output req_in, data_in, ack_in,
    input  ack_out, req_out, data_out
  );

  modport slave (
    input  req_in, data_in, ack_in,
    output ack_out, req_out, data_out
  );

endinterface

// File: rtl/sync_bit.sv
// Single-bit synchronizer: STAGES-deep flop chain, async active-high reset to 0; STAGES=0 is a wire.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign o_q = i_d;
    end else begin : g_chain
      logic [STAGES-1:0] r_chain;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_chain <= '0;
        end else begin
          r_chain[0] <= i_d;
          for (int k = 1; k < int'(STAGES); k++) begin
            r_chain[k] <= r_chain[k-1];
          end
        end
      end

      assign o_q = r_chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/pipeline_stage.sv
// One-token two-phase micro-pipeline stage: forwards a token when upstream has one pending
// and downstream has acknowledged the previous one.
module pipeline_stage
  import pipeline_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_stage_if.slave   i_bus
);

  phase_t              w_req_s;
  phase_t              w_ack_s;
  logic                w_pending;
  logic                w_free;
  logic                w_fire;

  phase_t              r_req_out;
  phase_t              r_ack_out;
  logic [DATA_W-1:0]   r_data_out;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .i_d (i_bus.req_in),
    .o_q (w_req_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .i_d (i_bus.ack_in),
    .o_q (w_ack_s)
  );

  // data_in is not synchronized: bundling keeps it stable until ack_out toggles.
  assign w_pending = (w_req_s != r_ack_out);
  assign w_free    = (w_ack_s == r_req_out);
  assign w_fire    = w_pending & w_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_out  <= 1'b0;
      r_ack_out  <= 1'b0;
      r_data_out <= '0;
    end else if (w_fire) begin
      r_data_out <= i_bus.data_in;
      r_req_out  <= phase_flip(r_req_out);
      r_ack_out  <= phase_flip(r_ack_out);
    end
  end

  assign i_bus.req_out  = r_req_out;
  assign i_bus.ack_out  = r_ack_out;
  assign i_bus.data_out = r_data_out;

endmodule

// File: tb/tb_pipeline_stage.sv
// Self-checking bench for pipeline_stage: directed latency/backpressure/reset cases and a
// token-queue reference model fed by random and incrementing streams.
module tb_pipeline_stage;
  import pipeline_stage_pkg::*;

  localparam int unsigned DW   = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned LAT  = SYNC + 1;

  logic clk = 1'b0;
  logic rst;
  logic rst0;

  pipeline_stage_if #(.DATA_W(DW)) bus  ();
  pipeline_stage_if #(.DATA_W(DW)) bus0 ();

  pipeline_stage #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst   (rst),
    .i_bus (bus)
  );

  pipeline_stage #(.DATA_W(DW), .SYNC_STAGES(0)) dut0 (
    .clk   (clk),
    .rst   (rst0),
    .i_bus (bus0)
  );

  int checks = 0;
  int errors = 0;
  int n_fwd  = 0;
  logic [DW-1:0] q_exp[$];

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_in  = 1'($urandom);
      bus.ack_in  = 1'($urandom);
      bus.data_in = DW'($urandom);
      tick();
      checks++;
      if (bus.req_out !== 1'b0 || bus.ack_out !== 1'b0 || bus.data_out !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got req=%b ack=%b data=%0d expected 0 0 0",
                 bus.req_out, bus.ack_out, bus.data_out);
      end
    end
  endtask

  task automatic test_first_token();
    bus.req_in  = 1'b1;
    bus.ack_in  = 1'b0;
    bus.data_in = DW'(1);
    tick();
    rst = 1'b0;
    tick(SYNC);
    checks++;
    if (bus.req_out !== 1'b0 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL first_early: got req=%b data=%0d expected 0 0", bus.req_out, bus.data_out);
    end
    tick();
    n_fwd = 1;
    checks++;
    if (bus.req_out !== 1'b1 || bus.ack_out !== 1'b1 || bus.data_out !== DW'(1)) begin
      errors++;
      $display("FAIL first_token: got req=%b ack=%b data=%0d expected 1 1 1",
               bus.req_out, bus.ack_out, bus.data_out);
    end
  endtask

  task automatic test_backpressure();
    bus.req_in  = 1'b0;
    bus.data_in = DW'(2);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.data_out !== DW'(1) || bus.ack_out !== 1'b1 || bus.req_out !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold: cycle %0d got data=%0d ack=%b req=%b expected 1 1 1",
                 i, bus.data_out, bus.ack_out, bus.req_out);
      end
    end
    bus.ack_in = 1'b1;
    tick(SYNC);
    checks++;
    if (bus.data_out !== DW'(1)) begin
      errors++;
      $display("FAIL backpressure_early: got data=%0d expected 1", bus.data_out);
    end
    tick();
    n_fwd = 2;
    checks++;
    if (bus.data_out !== DW'(2) || bus.req_out !== 1'b0 || bus.ack_out !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: got data=%0d req=%b ack=%b expected 2 0 0",
               bus.data_out, bus.req_out, bus.ack_out);
    end
    bus.ack_in = 1'b0;
    tick(LAT + 1);
    checks++;
    if (bus.req_out !== 1'(n_fwd) || bus.data_out !== DW'(2)) begin
      errors++;
      $display("FAIL backpressure_idle: got req=%b data=%0d expected %b 2",
               bus.req_out, bus.data_out, 1'(n_fwd));
    end
  endtask

  // Upstream and downstream agents around a queue of tokens in flight.
  task automatic test_closed_loop(input bit rnd, input int ntok);
    logic [DW-1:0] val;
    val = DW'(3);
    q_exp.delete();
    fork
      begin : upstream
        for (int i = 0; i < ntok; i++) begin
          int w;
          w = 0;
          while (bus.ack_out !== bus.req_in && w < 200) begin
            tick();
            w++;
          end
          if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL loop_up_timeout: token %0d ack_out=%b req_in=%b", i, bus.ack_out, bus.req_in);
            break;
          end
          tick(rnd ? int'($urandom_range(0, 4)) : 2);
          bus.data_in = rnd ? DW'($urandom) : val;
          q_exp.push_back(bus.data_in);
          bus.req_in = ~bus.req_in;
          val = val + DW'(1);
        end
      end
      begin : downstream
        for (int j = 0; j < ntok; j++) begin
          int w;
          logic [DW-1:0] exp_d;
          w = 0;
          while (bus.req_out === bus.ack_in && w < 200) begin
            tick();
            w++;
          end
          if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL loop_dn_timeout: token %0d req_out=%b ack_in=%b", j, bus.req_out, bus.ack_in);
            break;
          end
          checks++;
          if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL loop_extra_token: token %0d data=%0d expected none", j, bus.data_out);
          end else begin
            exp_d = q_exp.pop_front();
            if (bus.data_out !== exp_d) begin
              errors++;
              $display("FAIL loop_data: token %0d got %0d expected %0d", j, bus.data_out, exp_d);
            end
          end
          tick(rnd ? int'($urandom_range(0, 5)) : 3);
          bus.ack_in = bus.req_out;
        end
      end
    join
    n_fwd = n_fwd + ntok;
    tick(10);
    checks++;
    if (q_exp.size() != 0 || bus.req_out !== 1'(n_fwd) || bus.ack_out !== 1'(n_fwd)) begin
      errors++;
      $display("FAIL loop_end: got left=%0d req=%b ack=%b expected 0 %b %b",
               q_exp.size(), bus.req_out, bus.ack_out, 1'(n_fwd), 1'(n_fwd));
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = DW'($urandom);
    b = a ^ DW'($urandom_range(1, (1 << DW) - 1));
    bus.data_in = a;
    bus.req_in  = ~bus.req_in;
    tick(LAT);
    n_fwd++;
    checks++;
    if (bus.data_out !== a || bus.req_out !== 1'(n_fwd)) begin
      errors++;
      $display("FAIL simul_first: got data=%0d req=%b expected %0d %b", bus.data_out, bus.req_out, a, 1'(n_fwd));
    end
    bus.data_in = b;
    bus.req_in  = ~bus.req_in;
    bus.ack_in  = 1'(n_fwd);
    tick(SYNC);
    checks++;
    if (bus.data_out !== a || bus.req_out !== 1'(n_fwd)) begin
      errors++;
      $display("FAIL simul_early: got data=%0d req=%b expected %0d %b", bus.data_out, bus.req_out, a, 1'(n_fwd));
    end
    tick();
    n_fwd++;
    checks++;
    if (bus.data_out !== b || bus.req_out !== 1'(n_fwd) || bus.ack_out !== 1'(n_fwd)) begin
      errors++;
      $display("FAIL simul_fire: got data=%0d req=%b ack=%b expected %0d %b %b",
               bus.data_out, bus.req_out, bus.ack_out, b, 1'(n_fwd), 1'(n_fwd));
    end
    tick(10);
    checks++;
    if (bus.data_out !== b || bus.req_out !== 1'(n_fwd)) begin
      errors++;
      $display("FAIL simul_single: got data=%0d req=%b expected %0d %b", bus.data_out, bus.req_out, b, 1'(n_fwd));
    end
    bus.ack_in = 1'(n_fwd);
    tick(LAT + 1);
  endtask

  task automatic test_mid_reset();
    bus.data_in = DW'(5);
    bus.req_in  = ~bus.req_in;
    tick(LAT);
    n_fwd++;
    checks++;
    if (bus.data_out !== DW'(5)) begin
      errors++;
      $display("FAIL midrst_setup: got data=%0d expected 5", bus.data_out);
    end
    bus.data_in = DW'(6);
    bus.req_in  = ~bus.req_in;
    tick(LAT);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_out !== 1'b0 || bus.ack_out !== 1'b0 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL midrst_async: got req=%b ack=%b data=%0d expected 0 0 0",
               bus.req_out, bus.ack_out, bus.data_out);
    end
    bus.req_in  = 1'b1;
    bus.ack_in  = 1'b0;
    bus.data_in = DW'(1);
    tick();
    rst = 1'b0;
    n_fwd = 0;
    tick(SYNC);
    checks++;
    if (bus.req_out !== 1'b0 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL midrst_early: got req=%b data=%0d expected 0 0", bus.req_out, bus.data_out);
    end
    tick();
    n_fwd = 1;
    checks++;
    if (bus.req_out !== 1'b1 || bus.ack_out !== 1'b1 || bus.data_out !== DW'(1)) begin
      errors++;
      $display("FAIL midrst_first: got req=%b ack=%b data=%0d expected 1 1 1",
               bus.req_out, bus.ack_out, bus.data_out);
    end
  endtask

  // Unsynchronized variant: one edge from request to fire.
  task automatic test_sync0();
    int n0;
    checks++;
    if (bus0.req_out !== 1'b0 || bus0.ack_out !== 1'b0 || bus0.data_out !== '0) begin
      errors++;
      $display("FAIL s0_reset: got req=%b ack=%b data=%0d expected 0 0 0",
               bus0.req_out, bus0.ack_out, bus0.data_out);
    end
    bus0.req_in  = 1'b1;
    bus0.ack_in  = 1'b0;
    bus0.data_in = DW'(1);
    rst0 = 1'b0;
    #1;
    checks++;
    if (bus0.req_out !== 1'b0) begin
      errors++;
      $display("FAIL s0_early: got req=%b expected 0", bus0.req_out);
    end
    tick();
    checks++;
    if (bus0.req_out !== 1'b1 || bus0.ack_out !== 1'b1 || bus0.data_out !== DW'(1)) begin
      errors++;
      $display("FAIL s0_first: got req=%b ack=%b data=%0d expected 1 1 1",
               bus0.req_out, bus0.ack_out, bus0.data_out);
    end
    bus0.data_in = DW'(7);
    bus0.req_in  = 1'b0;
    tick();
    #2;
    rst0 = 1'b1;
    #1;
    checks++;
    if (bus0.req_out !== 1'b0 || bus0.ack_out !== 1'b0 || bus0.data_out !== '0) begin
      errors++;
      $display("FAIL s0_midrst: got req=%b ack=%b data=%0d expected 0 0 0",
               bus0.req_out, bus0.ack_out, bus0.data_out);
    end
    bus0.req_in  = 1'b1;
    bus0.data_in = DW'(1);
    tick();
    rst0 = 1'b0;
    tick();
    checks++;
    if (bus0.req_out !== 1'b1 || bus0.ack_out !== 1'b1 || bus0.data_out !== DW'(1)) begin
      errors++;
      $display("FAIL s0_refirst: got req=%b ack=%b data=%0d expected 1 1 1",
               bus0.req_out, bus0.ack_out, bus0.data_out);
    end
    n0 = 1;
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      bus0.ack_in  = 1'(n0);
      bus0.data_in = d;
      bus0.req_in  = ~bus0.req_in;
      tick();
      n0++;
      checks++;
      if (bus0.data_out !== d || bus0.req_out !== 1'(n0)) begin
        errors++;
        $display("FAIL s0_stream: token %0d got data=%0d req=%b expected %0d %b",
                 i, bus0.data_out, bus0.req_out, d, 1'(n0));
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    rst0         = 1'b1;
    bus.req_in   = 1'b0;
    bus.ack_in   = 1'b0;
    bus.data_in  = '0;
    bus0.req_in  = 1'b0;
    bus0.ack_in  = 1'b0;
    bus0.data_in = '0;
    test_reset();
    test_first_token();
    test_backpressure();
    test_closed_loop(1'b0, 40);
    test_closed_loop(1'b1, 60);
    test_simultaneous();
    test_mid_reset();
    test_sync0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
